// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// Each access runs IDLE -> ADDR -> XFER -> DONE; reads stretch XFER to RD_LAT cycles.
module ram_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [7:0]  addr0,
  input  logic [7:0]  addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic [7:0]  ram_addr,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  output logic        ram_we,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADDR, XFER, DONE} state_t;

  state_t     state, state_nx;
  logic       op_we;
  logic       gnt;
  logic       last_gnt;
  logic       start;
  logic       win;
  logic [1:0] cnt;

  // Requesters hold req until ack, so a level request raised while busy
  // is still present and gets arbitrated in the next IDLE cycle.
  assign start = (state == IDLE) && (req0 || req1);
  assign win   = (req0 && req1) ? !last_gnt : req1;

  always_comb begin
    state_nx = state;
    ram_we   = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = ADDR;
      ADDR: state_nx = XFER;
      XFER: begin
        if (op_we) begin
          ram_we   = 1'b1;
          mdr_in   = 1'b1;
          state_nx = DONE;
        end else if (cnt == 2'd0) begin
          mdr_out  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        ack0     = !gnt;
        ack1     = gnt;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      gnt      <= 1'b0;
      op_we    <= 1'b0;
      cnt      <= 2'd0;
    end else begin
      state <= state_nx;
      if (start) begin
        gnt      <= win;
        last_gnt <= win;
        op_we    <= win ? we1 : we0;
        cnt      <= 2'(RD_LAT - 1);
      end else if (state == XFER && cnt != 2'd0) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Address/data registers are cleared by reset so the RAM sees a known bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= 8'd0;
      ram_wdata <= 16'd0;
      rdata     <= 16'd0;
    end else begin
      if (start) begin
        ram_addr  <= win ? addr1 : addr0;
        ram_wdata <= win ? wdata1 : wdata0;
      end
      if (mdr_out) rdata <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: two instances (RD_LAT=1 and RD_LAT=3) against a
// timestamp-based transaction model, plus directed literal expectations.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0 [2];
  logic        req1 [2];
  logic        we0 [2];
  logic        we1 [2];
  logic [7:0]  addr0 [2];
  logic [7:0]  addr1 [2];
  logic [15:0] wdata0 [2];
  logic [15:0] wdata1 [2];
  logic        ack0 [2];
  logic        ack1 [2];
  logic [15:0] rdata [2];
  logic [7:0]  ram_addr [2];
  logic [15:0] ram_wdata [2];
  logic [15:0] ram_rdata [2];
  logic        ram_we [2];
  logic        mdr_in [2];
  logic        mdr_out [2];
  logic        busy [2];

  logic [15:0] mem [2][256];
  logic        pl_en = 1'b0;
  int          pl_d;
  logic [7:0]  pl_a;
  logic [15:0] pl_v;

  int vectors = 0;
  int miscompares = 0;

  ram_arbiter #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata(rdata[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0]),
    .ram_we(ram_we[0]), .mdr_in(mdr_in[0]), .mdr_out(mdr_out[0]), .busy(busy[0])
  );

  ram_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata(rdata[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1]),
    .ram_we(ram_we[1]), .mdr_in(mdr_in[1]), .mdr_out(mdr_out[1]), .busy(busy[1])
  );

  // RAM: address is stable throughout XFER, so an asynchronous read satisfies any RD_LAT.
  assign ram_rdata[0] = mem[0][ram_addr[0]];
  assign ram_rdata[1] = mem[1][ram_addr[1]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_d][pl_a] <= pl_v;
    for (int d = 0; d < 2; d++)
      if (ram_we[d]) mem[d][ram_addr[d]] <= ram_wdata[d];
  end

  // ---------------- transaction model ----------------
  int          t = 0;
  bit          m_ok = 1'b0;
  bit          m_act [2];
  bit          m_we [2];
  bit          m_port [2];
  bit          m_last [2];
  int          m_k [2];
  logic [7:0]  m_ra [2];
  logic [15:0] m_rw [2];
  logic [15:0] m_rd [2];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // cycle index (0 = first cycle after the grant edge) of the ack cycle
  function automatic int dlast(input int d);
    return m_we[d] ? 2 : lat(d) + 1;
  endfunction

  always @(posedge clk) begin
    t = t + 1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_act[d]  = 1'b0;
        m_last[d] = 1'b1;
        m_ra[d]   = 8'd0;
        m_rw[d]   = 16'd0;
        m_rd[d]   = 16'd0;
        m_ok      = 1'b1;
      end else if (m_act[d]) begin
        if (!m_we[d] && (t - m_k[d] - 1) == lat(d)) m_rd[d] = mem[d][m_ra[d]];
        if ((t - m_k[d] - 1) == dlast(d)) m_act[d] = 1'b0;
      end else if (req0[d] || req1[d]) begin
        m_port[d] = (req0[d] && req1[d]) ? !m_last[d] : req1[d];
        m_last[d] = m_port[d];
        m_we[d]   = m_port[d] ? we1[d] : we0[d];
        m_ra[d]   = m_port[d] ? addr1[d] : addr0[d];
        m_rw[d]   = m_port[d] ? wdata1[d] : wdata0[d];
        m_k[d]    = t;
        m_act[d]  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      for (int d = 0; d < 2; d++) begin
        int          dd;
        logic [45:0] exp_v;
        logic [45:0] got_v;
        dd = t - m_k[d];
        exp_v = {m_act[d] && dd == dlast(d) && !m_port[d],
                 m_act[d] && dd == dlast(d) && m_port[d],
                 m_act[d],
                 m_act[d] && m_we[d] && dd == 1,
                 m_act[d] && m_we[d] && dd == 1,
                 m_act[d] && !m_we[d] && dd == lat(d),
                 m_ra[d], m_rw[d], m_rd[d]};
        got_v = {ack0[d], ack1[d], busy[d], ram_we[d], mdr_in[d], mdr_out[d],
                 ram_addr[d], ram_wdata[d], rdata[d]};
        vectors++;
        if (got_v !== exp_v) begin
          miscompares++;
          $display("FAIL outputs dut%0d edge %0d: got %h want %h (ack0,ack1,busy,we,mdi,mdo,addr,wdata,rdata)",
                   d, t, got_v, exp_v);
        end
      end
    end
  end

  // ---------------- observation monitors ----------------
  int cnt_we [2];
  int cnt_mo [2];
  int ack_q [$];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_we[d] === 1'b1) cnt_we[d]++;
      if (mdr_out[d] === 1'b1) cnt_mo[d]++;
    end
    if (ack0[0] === 1'b1) ack_q.push_back(0);
    if (ack1[0] === 1'b1) ack_q.push_back(1);
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic preload(input int d, input logic [7:0] a, input logic [15:0] v);
    pl_d = d; pl_a = a; pl_v = v; pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic set_req(input int d, input bit p, input bit v);
    if (p) req1[d] = v; else req0[d] = v;
  endtask

  // One access from an idle arbiter; lat counts edges from the grant edge to the ack cycle.
  task automatic xact(input int d, input bit p, input bit w, input logic [7:0] a,
                      input logic [15:0] wd, input bit drop_early, output int n);
    bit got;
    @(negedge clk);
    if (p) begin we1[d] = w; addr1[d] = a; wdata1[d] = wd; end
    else   begin we0[d] = w; addr0[d] = a; wdata0[d] = wd; end
    set_req(d, p, 1'b1);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (drop_early && n == 1) set_req(d, p, 1'b0);
      if ((p ? ack1[d] : ack0[d]) === 1'b1) begin
        got = 1'b1;
        set_req(d, p, 1'b0);
      end
    end
    if (!got) begin
      n = -1;
      set_req(d, p, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req0[d] = 1'b0; req1[d] = 1'b0; we0[d] = 1'b0; we1[d] = 1'b0;
      addr0[d] = 8'd0; addr1[d] = 8'd0; wdata0[d] = 16'd0; wdata1[d] = 16'd0;
      cnt_we[d] = 0; cnt_mo[d] = 0;
    end
    preload(0, 8'h2A, 16'h1234);
    preload(1, 8'h10, 16'hCAFE);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_rdata", int'(rdata[0]), 0);
    chk("reset_ram_addr", int'(ram_addr[0]), 0);
    rst = 1'b0;

    // read, RD_LAT=1
    cnt_mo[0] = 0;
    xact(0, 1'b0, 1'b0, 8'h2A, 16'h0000, 1'b0, n);
    chk("rd1_latency", n, 3);
    chk("rd1_rdata", int'(rdata[0]), 16'h1234);
    chk("rd1_mdr_out_cycles", cnt_mo[0], 1);

    // write from port 1
    cnt_we[0] = 0;
    xact(0, 1'b1, 1'b1, 8'h05, 16'hBEEF, 1'b0, n);
    chk("wr_latency", n, 3);
    chk("wr_ram_we_cycles", cnt_we[0], 1);
    chk("wr_ram_contents", int'(mem[0][8'h05]), 16'hBEEF);
    chk("wr_rdata_held", int'(rdata[0]), 16'h1234);

    // contention: both ports held, round-robin after a port-1 grant
    @(negedge clk);
    ack_q.delete();
    we0[0] = 1'b0; addr0[0] = 8'h2A;
    we1[0] = 1'b0; addr1[0] = 8'h05;
    req0[0] = 1'b1; req1[0] = 1'b1;
    for (int i = 0; i < 40 && ack_q.size() < 4; i++) begin
      @(negedge clk);
      #1;
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    chk("rr_ack_count", ack_q.size(), 4);
    if (ack_q.size() == 4) begin
      chk("rr_grant0", ack_q[0], 0);
      chk("rr_grant1", ack_q[1], 1);
      chk("rr_grant2", ack_q[2], 0);
      chk("rr_grant3", ack_q[3], 1);
    end

    // reset during the XFER of a write
    @(negedge clk);
    @(negedge clk);
    we0[0] = 1'b1; addr0[0] = 8'h33; wdata0[0] = 16'h5555; req0[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_xfer_we", int'(ram_we[0]), 1);
    rst = 1'b1;
    req0[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_ram_we", int'(ram_we[0]), 0);
    chk("abort_ack0", int'(ack0[0]), 0);
    chk("abort_ram_addr", int'(ram_addr[0]), 0);
    chk("abort_rdata", int'(rdata[0]), 0);
    rst = 1'b0;
    xact(0, 1'b0, 1'b0, 8'h05, 16'h0000, 1'b0, n);
    chk("post_reset_latency", n, 3);
    chk("post_reset_rdata", int'(rdata[0]), 16'hBEEF);

    // port 1 drops req during ADDR
    xact(0, 1'b1, 1'b0, 8'h2A, 16'h0000, 1'b1, n);
    chk("drop_latency", n, 3);
    chk("drop_rdata", int'(rdata[0]), 16'h1234);
    repeat (5) @(negedge clk);
    chk("drop_no_restart", int'(busy[0]), 0);

    // RD_LAT=3 read
    cnt_mo[1] = 0;
    xact(1, 1'b0, 1'b0, 8'h10, 16'h0000, 1'b0, n);
    chk("rd3_latency", n, 5);
    chk("rd3_rdata", int'(rdata[1]), 16'hCAFE);
    chk("rd3_mdr_out_cycles", cnt_mo[1], 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
